// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported RAM command/response port between the
// instruction-fetch (IF) and load/store (MEM) requesters of the multi-cycle CPU.
// One transaction is outstanding at a time. MEM has fixed priority, but after
// MAX_MEM_STREAK consecutive MEM grants taken while IF was waiting, the next
// tie goes to IF so that instruction fetch always makes progress.
module ram_arbiter #(
    parameter int DW             = 64,
    parameter int MW             = DW / 8,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic          arb_clk_i,
    input  logic          arb_rst_n_i,
    // instruction-fetch requester
    input  logic          if_req_i,
    input  logic [DW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    // load/store requester
    input  logic          mem_req_i,
    input  logic          mem_wen_i,
    input  logic [DW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic [MW-1:0] mem_wmask_i,
    output logic          mem_gnt_o,
    output logic          mem_rvalid_o,
    output logic [DW-1:0] mem_rdata_o,
    // RAM command/response port
    output logic          ram_req_o,
    output logic          ram_wen_o,
    output logic [DW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic [MW-1:0] ram_wmask_o,
    input  logic          ram_ready_i,
    input  logic          ram_rvalid_i,
    input  logic [DW-1:0] ram_rdata_i,
    // sticky protocol error
    output logic          arb_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_MEM_STREAK);

    state_e        state_q,     state_d;
    logic [3:0]    streak_q,    streak_d;
    logic          owner_mem_q, owner_mem_d;
    logic          wen_q,       wen_d;
    logic [DW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic [MW-1:0] wmask_q,     wmask_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          err_q,       err_d;

    logic grant_if;
    logic grant_mem;
    logic rsp_hit;

    // Pick the winner in IDLE: MEM unless IF has been passed over MAX_MEM_STREAK times.
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state_q == S_IDLE) begin
            if (mem_req_i && (!if_req_i || streak_q != STREAK_MAX)) begin
                grant_mem = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end
    end

    // Next state, command capture, streak bookkeeping and response routing.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // branches below leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        streak_d    = streak_q;
        owner_mem_d = owner_mem_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;

        // A response while nothing is waiting for one is a RAM protocol error.
        if (ram_rvalid_i && state_q != S_WAIT) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!if_req_i) begin
                    streak_d = '0;
                end
                if (grant_mem) begin
                    state_d     = S_ISSUE;
                    owner_mem_d = 1'b1;
                    wen_d       = mem_wen_i;
                    addr_d      = mem_addr_i;
                    wdata_d     = mem_wdata_i;
                    wmask_d     = mem_wmask_i;
                    if (if_req_i && streak_q < STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant_if) begin
                    state_d     = S_ISSUE;
                    owner_mem_d = 1'b0;
                    wen_d       = 1'b0;
                    addr_d      = if_addr_i;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    streak_d    = '0;
                end
            end
            S_ISSUE: begin
                if (ram_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ram_rvalid_i) begin
                    state_d = S_IDLE;
                    if (owner_mem_q) begin
                        mem_rdata_d = ram_rdata_i;
                    end else begin
                        if_rdata_d = ram_rdata_i;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge arb_clk_i or negedge arb_rst_n_i) begin
        if (!arb_rst_n_i) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            owner_mem_q <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, regardless of statement order.
            state_q     <= state_d;
            streak_q    <= streak_d;
            owner_mem_q <= owner_mem_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
        end
    end

    assign if_gnt_o  = grant_if;
    assign mem_gnt_o = grant_mem;

    // ram_req_o depends on state only, never on ram_ready_i or ram_rvalid_i.
    assign ram_req_o   = (state_q == S_ISSUE);
    assign ram_wen_o   = wen_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign ram_wmask_o = wmask_q;

    // Response goes straight through in its cycle, then the register holds it.
    assign rsp_hit      = (state_q == S_WAIT) && ram_rvalid_i;
    assign if_rvalid_o  = rsp_hit && !owner_mem_q;
    assign mem_rvalid_o = rsp_hit && owner_mem_q;
    assign if_rdata_o   = if_rvalid_o  ? ram_rdata_i : if_rdata_q;
    assign mem_rdata_o  = mem_rvalid_o ? ram_rdata_i : mem_rdata_q;

    assign arb_err_o = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. Directed scenarios plus
// a transaction-level engine that plays both requesters and the RAM, predicting
// grants from the fairness rule and routing from the outstanding-owner record.
module tb_ram_arbiter;

    localparam int DW   = 64;
    localparam int MW   = DW / 8;
    localparam int MAXS = 4;

    logic          arb_clk_i;
    logic          arb_rst_n_i;
    logic          if_req_i;
    logic [DW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          mem_req_i;
    logic          mem_wen_i;
    logic [DW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [MW-1:0] mem_wmask_i;
    logic          mem_gnt_o;
    logic          mem_rvalid_o;
    logic [DW-1:0] mem_rdata_o;
    logic          ram_req_o;
    logic          ram_wen_o;
    logic [DW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [MW-1:0] ram_wmask_o;
    logic          ram_ready_i;
    logic          ram_rvalid_i;
    logic [DW-1:0] ram_rdata_i;
    logic          arb_err_o;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.DW(DW), .MW(MW), .MAX_MEM_STREAK(MAXS)) dut (
        .arb_clk_i   (arb_clk_i),
        .arb_rst_n_i (arb_rst_n_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .mem_req_i   (mem_req_i),
        .mem_wen_i   (mem_wen_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wmask_i (mem_wmask_i),
        .mem_gnt_o   (mem_gnt_o),
        .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_req_o   (ram_req_o),
        .ram_wen_o   (ram_wen_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wmask_o (ram_wmask_o),
        .ram_ready_i (ram_ready_i),
        .ram_rvalid_i(ram_rvalid_i),
        .ram_rdata_i (ram_rdata_i),
        .arb_err_o   (arb_err_o)
    );

    initial arb_clk_i = 1'b0;
    always #5 arb_clk_i = ~arb_clk_i;

    task automatic idle_inputs();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        mem_req_i    = 1'b0;
        mem_wen_i    = 1'b0;
        mem_addr_i   = '0;
        mem_wdata_i  = '0;
        mem_wmask_i  = '0;
        ram_ready_i  = 1'b0;
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = '0;
    endtask

    task automatic test_reset();
        arb_rst_n_i = 1'b1;
        idle_inputs();
        #2 arb_rst_n_i = 1'b0;
        #1;
        checks++;
        if ({if_gnt_o, mem_gnt_o, if_rvalid_o, mem_rvalid_o, ram_req_o, ram_wen_o, arb_err_o,
             if_rdata_o, mem_rdata_o, ram_addr_o, ram_wdata_o, ram_wmask_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs req=%b rdata_if=%h rdata_mem=%h addr=%h err=%b, expected all 0",
                     ram_req_o, if_rdata_o, mem_rdata_o, ram_addr_o, arb_err_o);
        end
        @(negedge arb_clk_i);
        arb_rst_n_i = 1'b1;
        #1;
        checks++;
        if ({if_gnt_o, mem_gnt_o, ram_req_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got gnt_if/gnt_mem/req=%b expected 000", {if_gnt_o, mem_gnt_o, ram_req_o});
        end
        @(negedge arb_clk_i);
    endtask

    task automatic test_single_if();
        if_req_i  = 1'b1;
        if_addr_i = 64'h8000_0000;
        #1;
        checks++;
        if ({if_gnt_o, mem_gnt_o, ram_req_o} !== 3'b100) begin
            errors++;
            $display("FAIL single_if_gnt: got gnt_if/gnt_mem/req=%b expected 100", {if_gnt_o, mem_gnt_o, ram_req_o});
        end
        @(negedge arb_clk_i);
        if_req_i    = 1'b0;
        if_addr_i   = 64'hdead_beef;
        ram_ready_i = 1'b1;
        #1;
        checks++;
        if ({ram_req_o, ram_wen_o, ram_wmask_o, ram_addr_o} !== {1'b1, 1'b0, 8'h00, 64'h8000_0000}) begin
            errors++;
            $display("FAIL single_if_cmd: got req=%b wen=%b mask=%h addr=%h expected 1 0 00 80000000",
                     ram_req_o, ram_wen_o, ram_wmask_o, ram_addr_o);
        end
        @(negedge arb_clk_i);
        ram_ready_i  = 1'b0;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 64'h0000_0413;
        #1;
        checks++;
        if ({if_rvalid_o, mem_rvalid_o, ram_req_o, if_rdata_o} !== {3'b100, 64'h0000_0413}) begin
            errors++;
            $display("FAIL single_if_rsp: got rv_if=%b rv_mem=%b req=%b data=%h expected 1 0 0 413",
                     if_rvalid_o, mem_rvalid_o, ram_req_o, if_rdata_o);
        end
        @(negedge arb_clk_i);
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = 64'hffff_ffff_ffff_ffff;
        #1;
        checks++;
        if ({if_rvalid_o, if_rdata_o} !== {1'b0, 64'h0000_0413}) begin
            errors++;
            $display("FAIL single_if_hold: got rv_if=%b data=%h expected 0 413", if_rvalid_o, if_rdata_o);
        end
        @(negedge arb_clk_i);
    endtask

    task automatic test_mem_store();
        int pulses = 0;
        mem_req_i   = 1'b1;
        mem_wen_i   = 1'b1;
        mem_addr_i  = 64'h8000_1000;
        mem_wdata_i = 64'h1122_3344_5566_7788;
        mem_wmask_i = 8'h0f;
        #1;
        checks++;
        if ({mem_gnt_o, if_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL store_gnt: got gnt_mem/gnt_if=%b expected 10", {mem_gnt_o, if_gnt_o});
        end
        @(negedge arb_clk_i);
        idle_inputs();
        mem_wdata_i = 64'hcafe;
        for (int k = 0; k < 3; k++) begin
            ram_ready_i = (k == 2);
            #1;
            checks++;
            if ({ram_req_o, ram_wen_o, ram_addr_o, ram_wdata_o, ram_wmask_o} !==
                {1'b1, 1'b1, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'h0f}) begin
                errors++;
                $display("FAIL store_cmd_%0d: got req=%b wen=%b addr=%h wdata=%h mask=%h expected 1 1 80001000 1122334455667788 0f",
                         k, ram_req_o, ram_wen_o, ram_addr_o, ram_wdata_o, ram_wmask_o);
            end
            @(negedge arb_clk_i);
        end
        ram_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ram_rvalid_i = (k == 0);
            #1;
            if (mem_rvalid_o === 1'b1) pulses++;
            if (k == 0) begin
                checks++;
                if (ram_req_o !== 1'b0) begin
                    errors++;
                    $display("FAIL store_wait_req: got %b expected 0", ram_req_o);
                end
            end
            @(negedge arb_clk_i);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL store_rvalid_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        mem_req_i  = 1'b1;
        mem_addr_i = 64'h8000_2000;
        if_req_i   = 1'b1;
        if_addr_i  = 64'h8000_0040;
        #1;
        checks++;
        if ({mem_gnt_o, if_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL simul_first: got gnt_mem/gnt_if=%b expected 10", {mem_gnt_o, if_gnt_o});
        end
        @(negedge arb_clk_i);
        mem_req_i   = 1'b0;
        ram_ready_i = 1'b1;
        @(negedge arb_clk_i);
        ram_ready_i  = 1'b0;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 64'h0123_4567_89ab_cdef;
        #1;
        checks++;
        if ({mem_rvalid_o, if_rvalid_o, mem_rdata_o} !== {2'b10, 64'h0123_4567_89ab_cdef}) begin
            errors++;
            $display("FAIL simul_mem_rsp: got rv_mem=%b rv_if=%b data=%h expected 1 0 0123456789abcdef",
                     mem_rvalid_o, if_rvalid_o, mem_rdata_o);
        end
        @(negedge arb_clk_i);
        ram_rvalid_i = 1'b0;
        #1;
        checks++;
        if ({mem_gnt_o, if_gnt_o} !== 2'b01) begin
            errors++;
            $display("FAIL simul_second: got gnt_mem/gnt_if=%b expected 01", {mem_gnt_o, if_gnt_o});
        end
        @(negedge arb_clk_i);
        if_req_i    = 1'b0;
        ram_ready_i = 1'b1;
        #1;
        checks++;
        if (ram_addr_o !== 64'h8000_0040) begin
            errors++;
            $display("FAIL simul_if_addr: got %h expected 80000040", ram_addr_o);
        end
        @(negedge arb_clk_i);
        ram_ready_i  = 1'b0;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 64'h13;
        #1;
        checks++;
        if ({if_rvalid_o, mem_rvalid_o, if_rdata_o} !== {2'b10, 64'h13}) begin
            errors++;
            $display("FAIL simul_if_rsp: got rv_if=%b rv_mem=%b data=%h expected 1 0 13",
                     if_rvalid_o, mem_rvalid_o, if_rdata_o);
        end
        @(negedge arb_clk_i);
        idle_inputs();
        @(negedge arb_clk_i);
    endtask

    // Transaction engine. mode 0: random traffic and RAM delays; mode 1: both
    // requesters always asking, fastest RAM; mode 2: IF only, fastest RAM.
    task automatic run_engine(input int mode, input int n_txn, input string tag);
        logic          if_pend, mem_pend, mem_w, busy, accepted, own_mem;
        logic          exp_if, exp_mem, drv_ready, drv_rvalid, pat_if;
        logic [DW-1:0] if_a, mem_a, mem_d, c_addr, c_wdata, rsp_data;
        logic [MW-1:0] mem_m, c_wmask;
        logic          c_wen;
        int            ready_dly, resp_dly, wins, grants, resps, seen_rv, cyc, last_gnt, budget;
        if_pend = 1'b0; mem_pend = 1'b0; busy = 1'b0; accepted = 1'b0; own_mem = 1'b0;
        mem_w = 1'b0; if_a = '0; mem_a = '0; mem_d = '0; mem_m = '0;
        c_addr = '0; c_wdata = '0; c_wmask = '0; c_wen = 1'b0;
        ready_dly = 0; resp_dly = 0; wins = 0; grants = 0; resps = 0; seen_rv = 0;
        cyc = 0; last_gnt = -1;
        budget = n_txn * 30 + 50;
        while (resps < n_txn && cyc < budget) begin
            if (!if_pend && grants < n_txn && (mode != 0 || $urandom_range(0, 1) == 1)) begin
                if_pend = 1'b1;
                if_a    = {$urandom(), $urandom()};
            end
            if (!mem_pend && grants < n_txn && mode != 2 && (mode == 1 || $urandom_range(0, 1) == 1)) begin
                mem_pend = 1'b1;
                mem_w    = 1'($urandom_range(0, 1));
                mem_a    = {$urandom(), $urandom()};
                mem_d    = {$urandom(), $urandom()};
                mem_m    = MW'($urandom());
            end
            if_req_i     = if_pend;
            if_addr_i    = if_a;
            mem_req_i    = mem_pend;
            mem_wen_i    = mem_w;
            mem_addr_i   = mem_a;
            mem_wdata_i  = mem_d;
            mem_wmask_i  = mem_m;
            drv_ready    = busy && !accepted && ready_dly == 0;
            drv_rvalid   = busy && accepted && resp_dly == 0;
            rsp_data     = {$urandom(), $urandom()};
            ram_ready_i  = drv_ready;
            ram_rvalid_i = drv_rvalid;
            ram_rdata_i  = rsp_data;
            #1;
            // IF is owed the tie once MEM has won MAXS times in a row over it.
            exp_mem = !busy && mem_pend && (!if_pend || wins < MAXS);
            exp_if  = !busy && if_pend && !exp_mem;
            checks++;
            if ({if_gnt_o, mem_gnt_o} !== {exp_if, exp_mem}) begin
                errors++;
                $display("FAIL %s_gnt cyc %0d: got gnt_if/gnt_mem=%b expected %b", tag, cyc,
                         {if_gnt_o, mem_gnt_o}, {exp_if, exp_mem});
            end
            checks++;
            if (ram_req_o !== (busy && !accepted)) begin
                errors++;
                $display("FAIL %s_req cyc %0d: got %b expected %b", tag, cyc, ram_req_o, busy && !accepted);
            end
            if (busy && !accepted) begin
                checks++;
                if ({ram_wen_o, ram_addr_o, ram_wdata_o, ram_wmask_o} !== {c_wen, c_addr, c_wdata, c_wmask}) begin
                    errors++;
                    $display("FAIL %s_cmd cyc %0d: got wen=%b addr=%h wdata=%h mask=%h expected %b %h %h %h", tag, cyc,
                             ram_wen_o, ram_addr_o, ram_wdata_o, ram_wmask_o, c_wen, c_addr, c_wdata, c_wmask);
                end
            end
            checks++;
            if ({if_rvalid_o, mem_rvalid_o} !== {drv_rvalid && !own_mem, drv_rvalid && own_mem}) begin
                errors++;
                $display("FAIL %s_rvalid cyc %0d: got rv_if/rv_mem=%b expected %b", tag, cyc,
                         {if_rvalid_o, mem_rvalid_o}, {drv_rvalid && !own_mem, drv_rvalid && own_mem});
            end
            if (if_rvalid_o === 1'b1) seen_rv++;
            if (mem_rvalid_o === 1'b1) seen_rv++;
            if (drv_rvalid) begin
                checks++;
                if ((own_mem ? mem_rdata_o : if_rdata_o) !== rsp_data) begin
                    errors++;
                    $display("FAIL %s_rdata cyc %0d: got %h expected %h", tag, cyc,
                             own_mem ? mem_rdata_o : if_rdata_o, rsp_data);
                end
            end
            if (busy) begin
                if (!accepted) begin
                    if (drv_ready) begin
                        accepted = 1'b1;
                        resp_dly = (mode == 0) ? int'($urandom_range(0, 3)) : 0;
                    end else begin
                        ready_dly--;
                    end
                end else if (drv_rvalid) begin
                    busy = 1'b0;
                    resps++;
                end else begin
                    resp_dly--;
                end
            end else if (exp_if || exp_mem) begin
                if (mode == 1) begin
                    pat_if = (grants % (MAXS + 1)) == MAXS;
                    checks++;
                    if (if_gnt_o !== pat_if) begin
                        errors++;
                        $display("FAIL %s_order grant %0d: got if_gnt=%b expected %b", tag, grants, if_gnt_o, pat_if);
                    end
                end
                if (mode == 2 && last_gnt >= 0) begin
                    checks++;
                    if (cyc - last_gnt != 3) begin
                        errors++;
                        $display("FAIL %s_spacing grant %0d: got %0d cycles expected 3", tag, grants, cyc - last_gnt);
                    end
                end
                last_gnt  = cyc;
                grants++;
                busy      = 1'b1;
                accepted  = 1'b0;
                own_mem   = exp_mem;
                ready_dly = (mode == 0) ? int'($urandom_range(0, 3)) : 0;
                if (exp_mem) begin
                    c_wen    = mem_w;
                    c_addr   = mem_a;
                    c_wdata  = mem_d;
                    c_wmask  = mem_m;
                    wins     = if_pend ? wins + 1 : 0;
                    mem_pend = 1'b0;
                end else begin
                    c_wen   = 1'b0;
                    c_addr  = if_a;
                    c_wdata = '0;
                    c_wmask = '0;
                    wins    = 0;
                    if_pend = 1'b0;
                end
            end else if (!if_pend) begin
                wins = 0;
            end
            cyc++;
            @(negedge arb_clk_i);
        end
        checks++;
        if (cyc >= budget || seen_rv != n_txn) begin
            errors++;
            $display("FAIL %s_count: got %0d rvalid pulses in %0d cycles expected %0d", tag, seen_rv, cyc, n_txn);
        end
        idle_inputs();
        @(negedge arb_clk_i);
    endtask

    task automatic test_reset_mid_op();
        mem_req_i  = 1'b1;
        mem_addr_i = 64'h8000_3000;
        @(negedge arb_clk_i);
        mem_req_i   = 1'b0;
        ram_ready_i = 1'b1;
        @(negedge arb_clk_i);
        ram_ready_i  = 1'b0;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 64'ha5a5_a5a5_5a5a_5a5a;
        @(negedge arb_clk_i);
        ram_rvalid_i = 1'b0;
        mem_req_i    = 1'b1;
        @(negedge arb_clk_i);
        mem_req_i   = 1'b0;
        ram_ready_i = 1'b1;
        @(negedge arb_clk_i);
        ram_ready_i = 1'b0;
        #2 arb_rst_n_i = 1'b0;
        #1;
        checks++;
        if ({if_gnt_o, mem_gnt_o, if_rvalid_o, mem_rvalid_o, ram_req_o, ram_wen_o, arb_err_o,
             if_rdata_o, mem_rdata_o, ram_addr_o, ram_wdata_o, ram_wmask_o} !== '0) begin
            errors++;
            $display("FAIL midop_reset_outputs: got req=%b rdata_mem=%h addr=%h err=%b, expected all 0",
                     ram_req_o, mem_rdata_o, ram_addr_o, arb_err_o);
        end
        @(negedge arb_clk_i);
        arb_rst_n_i  = 1'b1;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 64'h7777;
        #1;
        checks++;
        if ({mem_rvalid_o, if_rvalid_o, mem_rdata_o} !== {2'b00, 64'h0}) begin
            errors++;
            $display("FAIL midop_stale_rsp: got rv_mem=%b rv_if=%b data=%h expected 0 0 0",
                     mem_rvalid_o, if_rvalid_o, mem_rdata_o);
        end
        @(negedge arb_clk_i);
        ram_rvalid_i = 1'b0;
        #1;
        checks++;
        if (arb_err_o !== 1'b1) begin
            errors++;
            $display("FAIL midop_err_set: got %b expected 1", arb_err_o);
        end
        @(negedge arb_clk_i);
        @(negedge arb_clk_i);
        #1;
        checks++;
        if (arb_err_o !== 1'b1) begin
            errors++;
            $display("FAIL midop_err_sticky: got %b expected 1", arb_err_o);
        end
        #1 arb_rst_n_i = 1'b0;
        #1;
        checks++;
        if (arb_err_o !== 1'b0) begin
            errors++;
            $display("FAIL midop_err_clear: got %b expected 0", arb_err_o);
        end
        @(negedge arb_clk_i);
        arb_rst_n_i = 1'b1;
        @(negedge arb_clk_i);
    endtask

    initial begin
        test_reset();
        test_single_if();
        test_mem_store();
        test_simultaneous();
        run_engine(1, 15, "starve");
        run_engine(2, 100, "b2b");
        run_engine(0, 200, "random");
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
